// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and data-memory port bundle for the load/store unit
interface mem_access_unit_if #(
   parameter int ADDR_W = 11
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic [31:0]       mem_dout;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_dout,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_din
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a 1-cycle-latency single-port word memory
module mem_access_unit #(
   parameter int          ADDR_W     = 11,
   parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic              bad;
   logic [31:0]       lane, mask, ins;

   always_comb begin
      bad = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0])
         || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
         || (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
      lane = bus.mem_dout >> {addr_q[1:0], 3'b000};
      mask = size_q == 2'b00 ? 32'h0000_00FF << {addr_q[1:0], 3'b000} : 32'h0000_FFFF << {addr_q[1], 4'b0000};
      ins = size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
      state_d = state_q;
      we_d = we_q;
      uns_d = uns_q;
      err_d = err_q;
      size_d = size_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            we_d = bus.req_we;
            uns_d = bus.req_unsigned;
            size_d = bus.req_size;
            addr_d = bus.req_addr[ADDR_W+1:0];
            wdata_d = bus.req_wdata;
            err_d = bad;
            rdata_d = '0;
            state_d = bad ? RESP : ACCESS;
         end
         ACCESS: state_d = (we_q && size_q == 2'b10) ? RESP : WAIT;
         WAIT: if (we_q) begin
            // sub-word store: splice new lanes into the old word before the write-back
            wdata_d = (bus.mem_dout & ~mask) | (ins & mask);
            state_d = WRITE;
         end else begin
            rdata_d = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]}
                    : size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : bus.mem_dout;
            state_d = RESP;
         end
         WRITE: state_d = RESP;
         RESP: if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q <= 1'b0;
         uns_q <= 1'b0;
         err_q <= 1'b0;
         size_q <= 2'b00;
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= RESET_DATA;
      end else begin
         state_q <= state_d;
         we_q <= we_d;
         uns_q <= uns_d;
         err_q <= err_d;
         size_q <= size_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.req_ready = state_q == IDLE;
   assign bus.resp_valid = state_q == RESP;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err = err_q;
   // reset kills the memory strobes combinationally so an aborted RMW cannot write
   assign bus.mem_en = rst_n && (state_q == ACCESS || state_q == WRITE);
   assign bus.mem_we = rst_n && (state_q == WRITE || (state_q == ACCESS && we_q && size_q == 2'b10));
   assign bus.mem_addr = addr_q[ADDR_W+1:2];
   assign bus.mem_din = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a byte-level reference memory and a per-cycle response checker
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(11)) bus();
   mem_access_unit #(.ADDR_W(11), .RESET_DATA(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] bram [0:2047];
   logic [7:0]  ref_b [0:8191];
   logic [32:0] exp_q [$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        en_l [0:15];
   logic        we_l [0:15];
   logic [10:0] addr_l [0:15];
   logic [31:0] din_l [0:15];
   logic [31:0] rd;

   always @(posedge clk)
      if (bus.mem_en) begin
         if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
         else bus.mem_dout <= bram[bus.mem_addr];
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: byte-addressed memory, responses {err, rdata} queued in request order
   function automatic logic [32:0] model(input logic we, input logic [1:0] sz, input logic un,
                                         input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] v;
      int n;
      v = 32'h0;
      n = 1 << sz;
      if (sz == 2'b11 || a >= 32'h2000 || (a % n) != 0) return {1'b1, 32'h0};
      if (we) begin
         for (int i = 0; i < n; i++) ref_b[a + i] = wd[8*i +: 8];
         return {1'b0, 32'h0};
      end
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[a + i];
      if (!un && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!un && n == 2) v = {{16{v[15]}}, v[15:0]};
      return {1'b0, v};
   endfunction

   always @(negedge clk)
      if (rst_n && bus.resp_valid) begin
         if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
         else begin
            check("resp_rdata", bus.resp_rdata, exp_q[0][31:0]);
            check("resp_err", 32'(bus.resp_err), 32'(exp_q[0][32]));
            if (bus.resp_ready) void'(exp_q.pop_front());
         end
      end

   task automatic xact(input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
      logic [32:0] e;
      int lat, n_en, exp_lat, exp_acc;
      bit done;
      e = model(we, sz, un, a, wd);
      exp_lat = e[32] ? 1 : (we && sz == 2'b10) ? 2 : !we ? 3 : 4;
      exp_acc = e[32] ? 0 : (we && sz != 2'b10) ? 2 : 1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_size = sz;
      bus.req_unsigned = un;
      bus.req_addr = a;
      bus.req_wdata = wd;
      bus.resp_ready = (hold == 0);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_we = ~we;
      bus.req_size = ~sz;
      bus.req_unsigned = ~un;
      bus.req_addr = $urandom;
      bus.req_wdata = $urandom;
      lat = 0;
      n_en = 0;
      done = 1'b0;
      while (!done && lat < 12) begin
         @(negedge clk);
         lat++;
         en_l[lat] = bus.mem_en;
         we_l[lat] = bus.mem_we;
         addr_l[lat] = bus.mem_addr;
         din_l[lat] = bus.mem_din;
         n_en += int'(bus.mem_en);
         done = bus.resp_valid;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("mem_accesses", 32'(n_en), 32'(exp_acc));
      rd = bus.resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         bus.req_valid = 1'b1;
         bus.req_we = 1'b0;
         bus.req_size = 2'b10;
         bus.req_addr = 32'h14;
         @(negedge clk);
         check("hold_valid", 32'(bus.resp_valid), 32'd1);
         check("hold_rdata", bus.resp_rdata, rd);
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
         check("hold_mem_en", 32'(bus.mem_en), 32'd0);
      end
      if (hold > 0) begin
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
         bus.resp_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check("req_ready_after", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2048; i++) bram[i] = 32'h0;
      for (int i = 0; i < 8192; i++) ref_b[i] = 8'h0;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);

      xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
      check("ws_en", 32'(en_l[1]), 32'd1);
      check("ws_we", 32'(we_l[1]), 32'd1);
      check("ws_addr", 32'(addr_l[1]), 32'd4);
      check("ws_din", din_l[1], 32'hDEADBEEF);
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      check("lw_lit", rd, 32'hDEADBEEF);
      xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
      check("lb_s_lit", rd, 32'hFFFFFFDE);
      xact(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0);
      check("lbu_lit", rd, 32'h000000AD);
      xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
      check("lh_s_lit", rd, 32'hFFFFBEEF);
      xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
      check("lhu_lit", rd, 32'h0000DEAD);

      xact(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 0);
      check("sb_rd_en", 32'(en_l[1]), 32'd1);
      check("sb_rd_we", 32'(we_l[1]), 32'd0);
      check("sb_wait_en", 32'(en_l[2]), 32'd0);
      check("sb_wr_we", 32'(en_l[3] & we_l[3]), 32'd1);
      check("sb_wr_addr", 32'(addr_l[3]), 32'd4);
      check("sb_wr_din", din_l[3], 32'hDEAD55EF);
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      check("lw_after_sb", rd, 32'hDEAD55EF);
      xact(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD1234, 0);
      xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
      check("lw_after_sh", rd, 32'h12340000);

      xact(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0);
      check("err_w_mis", rd, 32'h0);
      xact(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 0);
      check("err_h_mis", rd, 32'h0);
      xact(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0);
      check("err_size", rd, 32'h0);
      xact(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 0);
      check("err_range", rd, 32'h0);
      xact(1'b1, 2'b01, 1'b0, 32'h5, 32'h1111, 0);
      xact(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 0);

      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
      check("stall_rdata", rd, 32'hDEAD55EF);

      // reset while a byte store sits in WAIT: the write-back must never happen
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_size = 2'b00;
      bus.req_addr = 32'h12;
      bus.req_wdata = 32'hAA;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("abort_wait_en", 32'(bus.mem_en), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort_en", 32'(bus.mem_en), 32'd0);
      check("abort_valid", 32'(bus.resp_valid), 32'd0);
      check("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("abort_rdata", bus.resp_rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      check("abort_mem_word", bram[4], 32'hDEAD55EF);

      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_size = 2'b10;
      bus.req_addr = 32'h30;
      bus.req_wdata = 32'h01020304;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_acc_en", 32'(bus.mem_en), 32'd0);
      check("abort_acc_we", 32'(bus.mem_we), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort2_req_ready", 32'(bus.req_ready), 32'd1);
      check("abort2_mem_word", bram[12], 32'h0);

      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      check("lw_after_abort", rd, 32'hDEAD55EF);
      for (int k = 0; k < 20; k++)
         xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), $urandom, 0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the 2048×32 data memory block (single-port BRAM, 1-cycle read latency, whole-word writes only).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake and drives the memory's en/we/addr/din.
- Formats read data: byte-lane extract, sign/zero extension.
- Implements byte/halfword stores as read-modify-write, because the memory has a single write enable.
- Returns one response per request.

Parameters:
ADDR_W, 11, word-address width of the data memory (2^ADDR_W words)
RESET_DATA, 32'h0000_0000, reset value of resp_rdata

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  formatted load data (0 for stores/errors)
resp_err  out  1  misaligned, out-of-range or reserved-size request
mem_en  out  1  to memory enable
mem_we  out  1  to memory write enable
mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
mem_din  out  32  write word
mem_dout  in  32  read word, valid the cycle after an en=1, we=0 access

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, resp_valid=0, resp_err=0, resp_rdata=RESET_DATA.
  - mem_en and mem_we are gated by rst_n, so no memory access in any cycle where rst_n=0, including mid-RMW.
  - A request aborted by reset produces no response.
- Handshake:
  - req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready.
  - All request fields are latched at acceptance; input changes afterwards are ignored.
  - Exactly one response per accepted request. The unit holds at most one outstanding request.
- Legality checks, on latched fields:
  - Error if size=11.
  - Error if halfword and addr[0]≠0, or word and addr[1:0]≠0.
  - Error if addr[31:ADDR_W+2]≠0.
  - An erroneous request does no memory access.
- FSM states: IDLE, ACCESS, WAIT, WRITE, RESP.
  - IDLE: accept → ACCESS if legal, else RESP with resp_err=1.
  - ACCESS: mem_en=1, mem_addr driven.
    - Word store: mem_we=1, mem_din=wdata, → RESP.
    - Load or sub-word store: mem_we=0 (read), → WAIT.
  - WAIT: mem_dout valid.
    - Load: extract lane addr[1:0] (byte) or addr[1] (half), little-endian, extend per req_unsigned, register into resp_rdata, → RESP.
    - Sub-word store: register merged word (old word with target byte/half lanes replaced by wdata[7:0]/[15:0]), → WRITE.
  - WRITE: mem_en=1, mem_we=1, mem_din=merged word, → RESP.
  - RESP: resp_valid=1, resp_rdata/resp_err stable; when resp_ready=1 → IDLE. resp_ready is ignored outside RESP.
- mem_en=mem_we=0 in IDLE, WAIT, RESP.
- Latency, with accept in cycle 0, resp_valid first high in:
  - error: cycle 1
  - word store: cycle 2
  - load: cycle 3
  - sub-word store: cycle 4
- Back-to-back throughput: the next request is accepted in the cycle after the response handshake (IDLE re-entered). No bypass.
- A load following a store to the same word returns the new data, since the store has completed before the load is accepted.
- resp_rdata=0 for stores and errors.

Test Plan:
- Reset, then word store 32'hDEADBEEF to addr 0x10 → mem_en=mem_we=1, mem_addr=4 in cycle 1; resp_valid cycle 2, err=0. Word load from 0x10 → resp_rdata=32'hDEADBEEF at cycle 3.
- Word 0x10 = DEADBEEF; load byte signed at 0x13 → 32'hFFFFFFDE; unsigned at 0x12 → 32'h000000AD; halfword signed at 0x10 → 32'hFFFFBEEF.
- Store byte 8'h55 to 0x11 over DEADBEEF → read at cycle 1, write at cycle 3 with mem_din=32'hDEAD55EF, resp_valid cycle 4; subsequent word load returns DEAD55EF.
- Misaligned word load at 0x6, halfword at 0x3, size=11, addr 0x0000_2000 → resp_err=1 at cycle 1, mem_en never asserted, resp_rdata=0.
- Hold resp_ready=0 for 5 cycles → resp_valid/rdata stable, req_ready=0, new req_valid ignored. Release → next request accepted the following cycle.
- rst_n low during WAIT of a sub-word store → no write cycle occurs, memory word unchanged, resp_valid=0, req_ready=1 after reset release.
